// File: rtl/vproc_vreg_wr_arbiter.sv
// Vector register file write-port arbiter: round-robin selection of up to
// PORT_WR_CNT same-cycle writes with distinct destination registers,
// registered onto the register file write ports.
module vproc_vreg_wr_arbiter #(
  parameter int unsigned REQ_CNT     = 4,
  parameter int unsigned PORT_WR_CNT = 2,
  parameter int unsigned MAX_PORT_W  = 512,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned REG_CNT     = 32
) (
  input  logic                                     clk_i,
  input  logic                                     async_rst_ni,
  input  logic [REQ_CNT-1:0]                       req_valid_i,
  output logic [REQ_CNT-1:0]                       req_ready_o,
  input  logic [REQ_CNT-1:0][ADDR_W-1:0]           req_addr_i,
  input  logic [REQ_CNT-1:0][MAX_PORT_W-1:0]       req_data_i,
  input  logic [REQ_CNT-1:0][MAX_PORT_W/8-1:0]     req_be_i,
  output logic [PORT_WR_CNT-1:0]                   wr_we_o,
  output logic [PORT_WR_CNT-1:0][ADDR_W-1:0]       wr_addr_o,
  output logic [PORT_WR_CNT-1:0][MAX_PORT_W-1:0]   wr_data_o,
  output logic [PORT_WR_CNT-1:0][MAX_PORT_W/8-1:0] wr_be_o,
  output logic [REG_CNT-1:0]                       wr_pend_o
);

  localparam int unsigned BE_W  = MAX_PORT_W / 8;
  localparam int unsigned RR_W  = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
  localparam int unsigned CNT_W = $clog2(PORT_WR_CNT + 1);

  logic [RR_W-1:0]                       r_rr;
  logic [PORT_WR_CNT-1:0]                r_we;
  logic [PORT_WR_CNT-1:0][ADDR_W-1:0]    r_addr;
  logic [PORT_WR_CNT-1:0][MAX_PORT_W-1:0] r_data;
  logic [PORT_WR_CNT-1:0][BE_W-1:0]      r_be;

  logic [REQ_CNT-1:0]                    w_ready;
  logic [PORT_WR_CNT-1:0]                w_gnt_vld;
  logic [PORT_WR_CNT-1:0][RR_W-1:0]      w_gnt_idx;
  logic [PORT_WR_CNT-1:0][ADDR_W-1:0]    w_gnt_addr;
  logic [CNT_W-1:0]                      w_cnt;
  logic [RR_W-1:0]                       w_rr_nxt;
  logic [RR_W-1:0]                       w_idx;
  logic                                  w_conflict;
  logic [REG_CNT-1:0]                    w_pend;

  // Requester index (base + off) wrapped modulo REQ_CNT; off never exceeds REQ_CNT.
  function automatic logic [RR_W-1:0] f_rr_add(input logic [RR_W-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= REQ_CNT) s = s - REQ_CNT;
    return RR_W'(s);
  endfunction

  // Circular grant scan from r_rr; skips requesters whose address is already granted.
  always_comb begin
    w_ready    = '0;
    w_gnt_vld  = '0;
    w_gnt_idx  = '0;
    w_gnt_addr = '0;
    w_cnt      = '0;
    w_rr_nxt   = r_rr;
    w_idx      = '0;
    w_conflict = 1'b0;
    for (int unsigned i = 0; i < REQ_CNT; i++) begin
      w_idx      = f_rr_add(r_rr, i);
      w_conflict = 1'b0;
      for (int unsigned p = 0; p < PORT_WR_CNT; p++) begin
        if ((p < 32'(w_cnt)) && (w_gnt_addr[p] == req_addr_i[w_idx])) w_conflict = 1'b1;
      end
      if (req_valid_i[w_idx] && (32'(w_cnt) < PORT_WR_CNT) && !w_conflict) begin
        w_ready[w_idx] = 1'b1;
        for (int unsigned p = 0; p < PORT_WR_CNT; p++) begin
          if (32'(w_cnt) == p) begin
            w_gnt_vld[p]  = 1'b1;
            w_gnt_idx[p]  = w_idx;
            w_gnt_addr[p] = req_addr_i[w_idx];
          end
        end
        w_cnt    = w_cnt + CNT_W'(1);
        w_rr_nxt = f_rr_add(w_idx, 1);
      end
    end
  end

  // No handshake may complete while reset is asserted.
  assign req_ready_o = w_ready & {REQ_CNT{async_rst_ni}};

  // Round-robin pointer and registered write-port stage.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      r_rr   <= '0;
      r_we   <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_be   <= '0;
    end else begin
      if (w_cnt != '0) r_rr <= w_rr_nxt;
      for (int unsigned p = 0; p < PORT_WR_CNT; p++) begin
        r_we[p] <= w_gnt_vld[p];
        if (w_gnt_vld[p]) begin
          r_addr[p] <= req_addr_i[w_gnt_idx[p]];
          r_data[p] <= req_data_i[w_gnt_idx[p]];
          r_be[p]   <= req_be_i[w_gnt_idx[p]];
        end else begin
          r_addr[p] <= '0;
          r_data[p] <= '0;
          r_be[p]   <= '0;
        end
      end
    end
  end

  // Registers with a write currently on the register file ports.
  always_comb begin
    w_pend = '0;
    for (int unsigned p = 0; p < PORT_WR_CNT; p++) begin
      if (r_we[p]) w_pend[r_addr[p]] = 1'b1;
    end
  end

  assign wr_we_o   = r_we;
  assign wr_addr_o = r_addr;
  assign wr_data_o = r_data;
  assign wr_be_o   = r_be;
  assign wr_pend_o = w_pend;

endmodule

// File: tb/tb_vproc_vreg_wr_arbiter.sv
// Self-checking bench for vproc_vreg_wr_arbiter: directed scenarios followed by
// random traffic, compared against a queue-based round-robin reference model.
module tb_vproc_vreg_wr_arbiter;

  localparam int R    = 4;
  localparam int P    = 2;
  localparam int AW   = 5;
  localparam int DW   = 64;
  localparam int BW   = DW / 8;
  localparam int NREG = 32;

  logic                       clk_i;
  logic                       async_rst_ni;
  logic [R-1:0]               req_valid;
  logic [R-1:0]               req_ready_o;
  logic [R-1:0][AW-1:0]       req_addr;
  logic [R-1:0][DW-1:0]       req_data;
  logic [R-1:0][BW-1:0]       req_be;
  logic [P-1:0]               wr_we_o;
  logic [P-1:0][AW-1:0]       wr_addr_o;
  logic [P-1:0][DW-1:0]       wr_data_o;
  logic [P-1:0][BW-1:0]       wr_be_o;
  logic [NREG-1:0]            wr_pend_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  int                   m_ptr;
  int                   m_nxt_ptr;
  logic [R-1:0]         exp_ready;
  logic [P-1:0]         exp_we,   nxt_we;
  logic [P-1:0][AW-1:0] exp_addr, nxt_addr;
  logic [P-1:0][DW-1:0] exp_data, nxt_data;
  logic [P-1:0][BW-1:0] exp_be,   nxt_be;

  vproc_vreg_wr_arbiter #(
    .REQ_CNT(R), .PORT_WR_CNT(P), .MAX_PORT_W(DW), .ADDR_W(AW), .REG_CNT(NREG)
  ) dut (
    .clk_i       (clk_i),
    .async_rst_ni(async_rst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_be_i    (req_be),
    .wr_we_o     (wr_we_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .wr_be_o     (wr_be_o),
    .wr_pend_o   (wr_pend_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREG-1:0] exp_pend();
    logic [NREG-1:0] m;
    m = '0;
    for (int p = 0; p < P; p++) if (exp_we[p]) m[exp_addr[p]] = 1'b1;
    return m;
  endfunction

  // Spec rule: visit requesters from the pointer, grant valid ones while ports
  // remain and the address is not yet taken; k-th grant goes to port k.
  task automatic model_eval();
    int q[$];
    int j;
    bit clash;
    exp_ready = '0;
    m_nxt_ptr = m_ptr;
    nxt_we = '0; nxt_addr = '0; nxt_data = '0; nxt_be = '0;
    for (int k = 0; k < R; k++) begin
      j = (m_ptr + k) % R;
      clash = 1'b0;
      foreach (q[n]) if (req_addr[q[n]] == req_addr[j]) clash = 1'b1;
      if (req_valid[j] && q.size() < P && !clash) begin
        q.push_back(j);
        exp_ready[j] = 1'b1;
        m_nxt_ptr = (j + 1) % R;
      end
    end
    foreach (q[n]) begin
      nxt_we[n]   = 1'b1;
      nxt_addr[n] = req_addr[q[n]];
      nxt_data[n] = req_data[q[n]];
      nxt_be[n]   = req_be[q[n]];
    end
  endtask

  task automatic zero_model();
    m_ptr = 0;
    exp_we = '0; exp_addr = '0; exp_data = '0; exp_be = '0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_we"},   wr_we_o,   exp_we);
    chk({tag, "_addr"}, wr_addr_o, exp_addr);
    chk({tag, "_data"}, wr_data_o, exp_data);
    chk({tag, "_be"},   wr_be_o,   exp_be);
    chk({tag, "_pend"}, wr_pend_o, exp_pend());
  endtask

  // One clock: check ready mid-cycle, then registered outputs after the edge.
  // Must be entered between a rising edge and the following falling edge.
  task automatic cycle(input string tag);
    model_eval();
    @(negedge clk_i);
    chk({tag, "_ready"}, req_ready_o, exp_ready);
    @(posedge clk_i);
    #1;
    m_ptr = m_nxt_ptr;
    exp_we = nxt_we; exp_addr = nxt_addr; exp_data = nxt_data; exp_be = nxt_be;
    chk_outputs(tag);
    for (int j = 0; j < R; j++) if (exp_ready[j]) req_valid[j] = 1'b0;
  endtask

  task automatic set_req(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] b);
    req_valid[j] = 1'b1;
    req_addr[j]  = a;
    req_data[j]  = d;
    req_be[j]    = b;
  endtask

  initial begin
    req_valid = '0; req_addr = '0; req_data = '0; req_be = '0;
    zero_model();

    // 1: reset held with all requesters valid
    async_rst_ni = 1'b0;
    for (int j = 0; j < R; j++) set_req(j, AW'(j + 1), DW'(j), '1);
    #12;
    chk("rst_ready", req_ready_o, '0);
    chk_outputs("rst");
    req_valid = '0;
    @(posedge clk_i);
    #2;
    async_rst_ni = 1'b1;
    cycle("idle0");
    cycle("idle1");

    // 2: single requester
    set_req(2, 5'd7, {8{8'hA5}}, '1);
    cycle("single");
    cycle("single_drain");

    // 3: four requesters, distinct addresses
    for (int j = 0; j < R; j++) set_req(j, AW'(j + 1), {$urandom, $urandom}, BW'($urandom));
    cycle("all4_a");
    cycle("all4_b");

    // 4: same-address conflict between req0 and req1
    set_req(0, 5'd4, {$urandom, $urandom}, '1);
    set_req(1, 5'd4, {$urandom, $urandom}, '1);
    set_req(2, 5'd9, {$urandom, $urandom}, '0);
    cycle("conf_a");
    cycle("conf_b");
    cycle("conf_c");

    // 6: asynchronous reset in the middle of a cycle with both ports busy
    set_req(0, 5'd1, {$urandom, $urandom}, '1);
    set_req(1, 5'd2, {$urandom, $urandom}, '1);
    cycle("pre_rst");
    #3;
    async_rst_ni = 1'b0;
    #1;
    zero_model();
    chk_outputs("arst");
    for (int j = 0; j < R; j++) set_req(j, AW'(j + 10), {$urandom, $urandom}, '1);
    chk("arst_ready", req_ready_o, '0);
    @(posedge clk_i);
    #2;
    async_rst_ni = 1'b1;
    cycle("post_rst");

    // random traffic with frequent address collisions and empty byte enables
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < R; j++) begin
        if (!req_valid[j] && $urandom_range(0, 1) == 1)
          set_req(j, AW'($urandom_range(0, 5)), {$urandom, $urandom},
                  ($urandom_range(0, 7) == 0) ? '0 : BW'($urandom));
      end
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
